prbs_checker: RTL and testbench

Receive-side PRBS-7 checker, the counterpart of the transmitter's PRBS generator. Sits after `clock_data_recovery` in the `clk_x8` sample domain: it takes recovered data plus the recovered bit clock, self-synchronises an LFSR to the incoming stream, and reports lock status, per-bit error pulses and running bit/error counts for link BER measurement.

---
 rtl/prbs_checker.sv | 141 ++++++++++++++
 tb/tb_prbs_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS-7 (x^7+x^6+1) receive checker: self-synchronising LFSR, lock/loss FSM, BER counters.
// Define PRBS_CHECK_SATURATE_EN to make bit_count/err_count saturate instead of wrapping.
module prbs_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int LOSS_WINDOW = 128,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_x8,
    input  logic                 rst,
    input  logic                 d_in,
    input  logic                 clk_in,
    input  logic                 clr_counts,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [7:0]           LOCK_CNT_L = LOCK_COUNT[7:0];
    localparam logic [15:0]          WINDOW_L   = LOSS_WINDOW[15:0];
    localparam logic [15:0]          THRESH_L   = LOSS_THRESH[15:0];
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 clk_in_q;
    logic [0:0]           state_q, state_d;
    logic [6:0]           s_q, s_d;
    logic [7:0]           match_cnt_q, match_cnt_d;
    logic [15:0]          win_bits_q, win_bits_d;
    logic [15:0]          win_err_q, win_err_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic        strobe;
    logic        pred;
    logic        bit_err;
    logic        bit_inc;
    logic        err_inc;
    logic [15:0] win_err_inc;

    assign strobe      = clk_in & ~clk_in_q;
    assign pred        = s_q[6] ^ s_q[5];
    assign bit_err     = d_in ^ pred;
    assign win_err_inc = win_err_q + {15'd0, bit_err};

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        match_cnt_d = match_cnt_q;
        win_bits_d  = win_bits_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;
        if (strobe) begin
            if (state_q == ST_SEARCH) begin
                s_d = {s_q[5:0], d_in};
                // An all-zero register predicts zero forever, so it must never count as a match.
                if ((s_q != 7'd0) && !bit_err) begin
                    match_cnt_d = match_cnt_q + 8'd1;
                    if (match_cnt_d == LOCK_CNT_L) begin
                        state_d    = ST_LOCKED;
                        win_bits_d = 16'd0;
                        win_err_d  = 16'd0;
                    end
                end else begin
                    match_cnt_d = 8'd0;
                end
            end else begin
                s_d         = {s_q[5:0], pred};
                bit_inc     = 1'b1;
                err_inc     = bit_err;
                err_pulse_d = bit_err;
                // The threshold sees the current bit before a window rollover can clear it.
                if (win_err_inc >= THRESH_L) begin
                    state_d     = ST_SEARCH;
                    match_cnt_d = 8'd0;
                    win_bits_d  = 16'd0;
                    win_err_d   = 16'd0;
                end else if ((win_bits_q + 16'd1) == WINDOW_L) begin
                    win_bits_d = 16'd0;
                    win_err_d  = 16'd0;
                end else begin
                    win_bits_d = win_bits_q + 16'd1;
                    win_err_d  = win_err_inc;
                end
            end
        end
    end

    always_comb begin
        bit_count_d = bit_count_q;
        err_count_d = err_count_q;
        if (clr_counts) begin
            bit_count_d = '0;
            err_count_d = '0;
        end else begin
`ifdef PRBS_CHECK_SATURATE_EN
            if (bit_inc && (bit_count_q != '1)) bit_count_d = bit_count_q + CNT_ONE;
            if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + CNT_ONE;
`else
            if (bit_inc) bit_count_d = bit_count_q + CNT_ONE;
            if (err_inc) err_count_d = err_count_q + CNT_ONE;
`endif
        end
    end

    always_ff @(posedge clk_x8) begin
        if (rst) begin
            clk_in_q    <= 1'b0;
            state_q     <= ST_SEARCH;
            s_q         <= 7'd0;
            match_cnt_q <= 8'd0;
            win_bits_q  <= 16'd0;
            win_err_q   <= 16'd0;
            err_pulse_q <= 1'b0;
            bit_count_q <= '0;
            err_count_q <= '0;
        end else begin
            clk_in_q    <= clk_in;
            state_q     <= state_d;
            s_q         <= s_d;
            match_cnt_q <= match_cnt_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            bit_count_q <= bit_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign bit_count = bit_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, isolated errors, loss/relock, clears, idle line,
// and a 4-bit counter instance whose expectation follows PRBS_CHECK_SATURATE_EN.
module tb_prbs_checker;

    logic        clk_x8 = 1'b0;
    logic        rst = 1'b0;
    logic        d_in = 1'b0;
    logic        clk_in = 1'b0;
    logic        clr_counts = 1'b0;
    logic        locked, err_pulse;
    logic [31:0] bit_count, err_count;
    logic        locked_s, err_pulse_s;
    logic [3:0]  bit_count_s, err_count_s;

    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    logic [6:0]  gen = 7'h7F;
    logic        last_locked = 1'b0;
    logic        ever_locked = 1'b0;

    prbs_checker #(.LOCK_COUNT(32), .LOSS_WINDOW(128), .LOSS_THRESH(16), .CNT_WIDTH(32)) dut (
        .clk_x8(clk_x8), .rst(rst), .d_in(d_in), .clk_in(clk_in), .clr_counts(clr_counts),
        .locked(locked), .err_pulse(err_pulse), .bit_count(bit_count), .err_count(err_count)
    );

    prbs_checker #(.LOCK_COUNT(32), .LOSS_WINDOW(128), .LOSS_THRESH(16), .CNT_WIDTH(4)) dut_small (
        .clk_x8(clk_x8), .rst(rst), .d_in(d_in), .clk_in(clk_in), .clr_counts(clr_counts),
        .locked(locked_s), .err_pulse(err_pulse_s), .bit_count(bit_count_s), .err_count(err_count_s)
    );

    always #5 clk_x8 = ~clk_x8;

    always @(negedge clk_x8) begin
        if (err_pulse === 1'b1) pulse_cnt++;
    end

    // One bit period is 8 clk_x8 cycles: clk_in high for 4, low for 4.
    task automatic send_bit(input logic b, input logic clr);
        @(negedge clk_x8);
        clk_in = 1'b1;
        d_in = b;
        clr_counts = clr;
        @(negedge clk_x8);
        clr_counts = 1'b0;
        last_locked = locked;
        if (locked === 1'b1) ever_locked = 1'b1;
        repeat (3) @(negedge clk_x8);
        clk_in = 1'b0;
        repeat (3) @(negedge clk_x8);
    endtask

    task automatic send_prbs(input int n, input logic inv);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = gen[6] ^ gen[5];
            gen = {gen[5:0], b};
            send_bit(b ^ inv, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_x8);
        rst = 1'b1;
        clk_in = 1'b0;
        d_in = 1'b0;
        clr_counts = 1'b0;
        @(negedge clk_x8);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %0b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_pulse got %0b want 0", err_pulse); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_bit_count got %0d want 0", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_err_count got %0d want 0", err_count); end
        checks++; if (err_count_s !== 4'd0) begin errors++; $display("[TB] FAIL reset_small_err_count got %0d want 0", err_count_s); end
    endtask

    task automatic test_lock();
        int p0;
        gen = 7'h7F;
        send_prbs(38, 1'b0);
        checks++; if (last_locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_early got %0b want 0 after bit 38", last_locked); end
        send_prbs(1, 1'b0);
        checks++; if (last_locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_bit39 got %0b want 1", last_locked); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL lock_search_bits got %0d want 0", bit_count); end
        p0 = pulse_cnt;
        send_prbs(1000, 1'b0);
        checks++; if (bit_count !== 32'd1000) begin errors++; $display("[TB] FAIL clean_bit_count got %0d want 1000", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("[TB] FAIL clean_err_count got %0d want 0", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL clean_locked got %0b want 1", locked); end
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("[TB] FAIL clean_pulses got %0d want 0", pulse_cnt - p0); end
    endtask

    task automatic test_isolated_errors();
        int p0;
        p0 = pulse_cnt;
        send_prbs(49, 1'b0); send_prbs(1, 1'b1);
        send_prbs(49, 1'b0); send_prbs(1, 1'b1);
        send_prbs(99, 1'b0); send_prbs(1, 1'b1);
        send_prbs(80, 1'b0);
        checks++; if (err_count !== 32'd3) begin errors++; $display("[TB] FAIL iso_err_count got %0d want 3", err_count); end
        checks++; if (bit_count !== 32'd1280) begin errors++; $display("[TB] FAIL iso_bit_count got %0d want 1280", bit_count); end
        checks++; if (pulse_cnt - p0 !== 3) begin errors++; $display("[TB] FAIL iso_pulses got %0d want 3", pulse_cnt - p0); end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL iso_locked got %0b want 1", locked); end
    endtask

    task automatic test_loss_relock();
        send_prbs(15, 1'b1);
        checks++; if (last_locked !== 1'b1) begin errors++; $display("[TB] FAIL burst15_locked got %0b want 1", last_locked); end
        send_prbs(1, 1'b1);
        checks++; if (last_locked !== 1'b0) begin errors++; $display("[TB] FAIL burst16_locked got %0b want 0", last_locked); end
        checks++; if (err_count !== 32'd19) begin errors++; $display("[TB] FAIL burst_err_count got %0d want 19", err_count); end
        checks++; if (bit_count !== 32'd1296) begin errors++; $display("[TB] FAIL burst_bit_count got %0d want 1296", bit_count); end
        send_prbs(31, 1'b0);
        checks++; if (last_locked !== 1'b0) begin errors++; $display("[TB] FAIL relock_early got %0b want 0", last_locked); end
        send_prbs(1, 1'b0);
        checks++; if (last_locked !== 1'b1) begin errors++; $display("[TB] FAIL relock got %0b want 1", last_locked); end
        checks++; if (bit_count !== 32'd1296) begin errors++; $display("[TB] FAIL relock_bit_count got %0d want 1296", bit_count); end
    endtask

    task automatic test_clr_same_cycle();
        int   p0;
        logic b;
        p0 = pulse_cnt;
        b = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
        send_bit(~b, 1'b1);
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL clr_bit_count got %0d want 0", bit_count); end
        checks++; if (err_count !== 32'd0) begin errors++; $display("[TB] FAIL clr_err_count got %0d want 0", err_count); end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("[TB] FAIL clr_pulse got %0d want 1", pulse_cnt - p0); end
        send_prbs(5, 1'b0);
        checks++; if (bit_count !== 32'd5) begin errors++; $display("[TB] FAIL post_clr_bits got %0d want 5", bit_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL post_clr_locked got %0b want 1", locked); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_x8);
        rst = 1'b1;
        clr_counts = 1'b1;
        @(negedge clk_x8);
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL midrst_locked got %0b want 0", locked); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL midrst_bit_count got %0d want 0", bit_count); end
        rst = 1'b0;
        clr_counts = 1'b0;
    endtask

    task automatic test_idle_low();
        ever_locked = 1'b0;
        repeat (500) send_bit(1'b0, 1'b0);
        checks++; if (ever_locked !== 1'b0) begin errors++; $display("[TB] FAIL idle_locked got %0b want 0", ever_locked); end
        checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL idle_bit_count got %0d want 0", bit_count); end
    endtask

    task automatic test_small_counter();
        int         p0;
        logic [3:0] exp_err;
        logic [3:0] exp_bits;
`ifdef PRBS_CHECK_SATURATE_EN
        exp_err  = 4'd15;
        exp_bits = 4'd15;
`else
        exp_err  = 4'd4;
        exp_bits = 4'd0;
`endif
        do_reset();
        gen = 7'h7F;
        send_prbs(39, 1'b0);
        p0 = pulse_cnt;
        repeat (20) begin
            send_prbs(15, 1'b0);
            send_prbs(1, 1'b1);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL spread_locked got %0b want 1", locked); end
        checks++; if (err_count !== 32'd20) begin errors++; $display("[TB] FAIL spread_err_count got %0d want 20", err_count); end
        checks++; if (pulse_cnt - p0 !== 20) begin errors++; $display("[TB] FAIL spread_pulses got %0d want 20", pulse_cnt - p0); end
        checks++; if (err_count_s !== exp_err) begin errors++; $display("[TB] FAIL small_err_count got %0d want %0d", err_count_s, exp_err); end
        checks++; if (bit_count_s !== exp_bits) begin errors++; $display("[TB] FAIL small_bit_count got %0d want %0d", bit_count_s, exp_bits); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_isolated_errors();
        test_loss_relock();
        test_clr_same_cycle();
        test_reset_mid();
        test_idle_low();
        test_small_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
